mmio_timer: RTL and testbench



---
 rtl/mmio_timer_pkg.sv | 20 ++
 rtl/mmio_timer_prescaler.sv | 28 ++
 rtl/mmio_timer.sv | 137 +++++++++++++
 tb/tb_mmio_timer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the mmio_timer peripheral: register offsets, CTRL/STATUS bit positions, widths.
package mmio_timer_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned PRESC_W = 8;

   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_COUNT   = 2'd1;
   localparam logic [1:0] OFF_COMPARE = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN      = 2;
   localparam int unsigned CTRL_PRESC_LSB   = 8;
   localparam int unsigned CTRL_PRESC_MSB   = 15;

   localparam int unsigned STATUS_MATCH = 0;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Tick generator: divides the clock by (presc+1) while enabled; used when MMIO_TIMER_PRESCALE_EN is defined.
module mmio_timer_prescaler
   import mmio_timer_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   input  logic               clear,
   output logic               tick_c
);

   logic [PRESC_W-1:0] pc;

   assign tick_c = en && (pc == presc);

   // A CTRL write restarts the divide period; the counter holds while disabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= '0;
      end else if (clear) begin
         pc <= '0;
      end else if (en) begin
         pc <= tick_c ? '0 : pc + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer/compare peripheral with registered read port and level interrupt.
// Optional clock prescaler enabled by defining MMIO_TIMER_PRESCALE_EN.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_FF00,
   parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   output logic              sel,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   logic              ctrlEn;
   logic              ctrlAutoReload;
   logic              ctrlIrqEn;
   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] compare;
   logic              match;

   logic              hit;
   logic [1:0]        offset;
   logic              rdHit;
   logic              wrCtrl;
   logic              wrCount;
   logic              wrCompare;
   logic              wrStatus;
   logic              tick;
   logic              cmpHit;
   logic [DATA_W-1:0] readValue;
   logic [DATA_W-1:0] countNext;
   logic              matchNext;
   logic              unusedAddrBits;

   assign hit            = (addr[31:4] == BASE_ADDR[31:4]);
   assign offset         = addr[3:2];
   assign rdHit          = hit && !wr;
   assign wrCtrl         = hit && wr && (offset == OFF_CTRL);
   assign wrCount        = hit && wr && (offset == OFF_COUNT);
   assign wrCompare      = hit && wr && (offset == OFF_COMPARE);
   assign wrStatus       = hit && wr && (offset == OFF_STATUS);
   assign unusedAddrBits = ^addr[1:0];

`ifdef MMIO_TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] ctrlPresc;

   mmio_timer_prescaler uPrescaler (
      .clock  (clock),
      .reset  (reset),
      .en     (ctrlEn),
      .presc  (ctrlPresc),
      .clear  (wrCtrl),
      .tick_c (tick)
   );
`else
   assign tick = ctrlEn;
`endif

   // Match compares the pre-edge COUNT against the pre-edge COMPARE.
   assign cmpHit = tick && (count == compare);

   always_comb begin
      readValue = '0;
      unique case (offset)
         OFF_CTRL: begin
            readValue[CTRL_EN]          = ctrlEn;
            readValue[CTRL_AUTO_RELOAD] = ctrlAutoReload;
            readValue[CTRL_IRQ_EN]      = ctrlIrqEn;
`ifdef MMIO_TIMER_PRESCALE_EN
            readValue[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = ctrlPresc;
`endif
         end
         OFF_COUNT:   readValue = count;
         OFF_COMPARE: readValue = compare;
         OFF_STATUS:  readValue[STATUS_MATCH] = match;
         default:     readValue = '0;
      endcase
   end

   // CPU writes to COUNT override the tick; a new match overrides W1C.
   always_comb begin
      countNext = count;
      matchNext = match;
      if (tick) begin
         countNext = (cmpHit && ctrlAutoReload) ? '0 : count + DATA_W'(1);
      end
      if (wrCount) begin
         countNext = wdata;
      end
      if (cmpHit) begin
         matchNext = 1'b1;
      end else if (wrStatus && wdata[STATUS_MATCH]) begin
         matchNext = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrlEn         <= 1'b0;
         ctrlAutoReload <= 1'b0;
         ctrlIrqEn      <= 1'b0;
`ifdef MMIO_TIMER_PRESCALE_EN
         ctrlPresc      <= '0;
`endif
         count          <= '0;
         compare        <= RESET_COMPARE;
         match          <= 1'b0;
         sel            <= 1'b0;
         rdata          <= '0;
         irq            <= 1'b0;
      end else begin
         sel   <= rdHit;
         rdata <= rdHit ? readValue : '0;
         irq   <= match && ctrlIrqEn;
         count <= countNext;
         match <= matchNext;
         if (wrCtrl) begin
            ctrlEn         <= wdata[CTRL_EN];
            ctrlAutoReload <= wdata[CTRL_AUTO_RELOAD];
            ctrlIrqEn      <= wdata[CTRL_IRQ_EN];
`ifdef MMIO_TIMER_PRESCALE_EN
            ctrlPresc      <= wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
`endif
         end
         if (wrCompare) begin
            compare <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_FF00;
   localparam logic [31:0] IDLE = 32'h0000_1000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        wr;
   logic [31:0] wdata;
   logic        sel;
   logic [31:0] rdata;
   logic        irq;

   int nChecks = 0;
   int nFails  = 0;

   // Behavioural model state
   logic        mEn, mAuto, mIrqEn, mMatch, mSel, mIrq;
   logic [7:0]  mPresc, mPc;
   logic [31:0] mCount, mCompare, mRdata;

   always #5 clock = ~clock;

   mmio_timer dut (
      .clock (clock),
      .reset (reset),
      .addr  (addr),
      .wr    (wr),
      .wdata (wdata),
      .sel   (sel),
      .rdata (rdata),
      .irq   (irq)
   );

   // One clock edge of the timer, written from the register-level rules.
   task automatic modelStep();
      logic        h;
      logic [1:0]  off;
      logic [31:0] rv;
      logic        tick;
      logic        isMatch;
      if (reset) begin
         mEn = 0; mAuto = 0; mIrqEn = 0; mMatch = 0; mSel = 0; mIrq = 0;
         mPresc = 0; mPc = 0; mCount = 0; mCompare = 32'hFFFF_FFFF; mRdata = 0;
         return;
      end
      h   = (addr >> 4) == (BASE >> 4);
      off = addr[3:2];
      case (off)
         2'd0:    rv = {16'h0, mPresc, 5'h0, mIrqEn, mAuto, mEn};
         2'd1:    rv = mCount;
         2'd2:    rv = mCompare;
         default: rv = {31'h0, mMatch};
      endcase
`ifdef MMIO_TIMER_PRESCALE_EN
      tick = mEn && (mPc == mPresc);
`else
      tick = mEn;
`endif
      isMatch = tick && (mCount == mCompare);
      mIrq   = mMatch && mIrqEn;
      mSel   = h && !wr;
      mRdata = (h && !wr) ? rv : 32'h0;
      if (h && wr && off == 2'd0) mPc = 0;
      else if (mEn) mPc = tick ? 8'd0 : mPc + 8'd1;
      if (tick) mCount = (isMatch && mAuto) ? 32'd0 : mCount + 32'd1;
      if (h && wr && off == 2'd1) mCount = wdata;
      if (isMatch) mMatch = 1;
      else if (h && wr && off == 2'd3 && wdata[0]) mMatch = 0;
      if (h && wr && off == 2'd2) mCompare = wdata;
      if (h && wr && off == 2'd0) begin
         mEn = wdata[0]; mAuto = wdata[1]; mIrqEn = wdata[2];
`ifdef MMIO_TIMER_PRESCALE_EN
         mPresc = wdata[15:8];
`endif
      end
   endtask

   // Drive one bus cycle from a falling edge through to the next falling edge.
   task automatic busCycle(input logic [31:0] a, input logic w, input logic [31:0] d);
      addr = a; wr = w; wdata = d;
      @(posedge clock);
      modelStep();
      @(negedge clock);
   endtask

   task automatic applyReset();
      reset = 1'b1;
      busCycle(IDLE, 1'b0, 32'h0);
      busCycle(IDLE, 1'b0, 32'h0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      nChecks++;
      if (sel !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
         nFails++; $display("FAIL reset_outputs: sel=%b rdata=%h irq=%b expected 0/0/0", sel, rdata, irq);
      end
      busCycle(BASE + 32'h4, 1'b0, 32'h0);
      nChecks++;
      if (sel !== 1'b1 || rdata !== 32'h0) begin
         nFails++; $display("FAIL reset_count: sel=%b rdata=%h expected 1/00000000", sel, rdata);
      end
      busCycle(BASE + 32'h8, 1'b0, 32'h0);
      nChecks++;
      if (sel !== 1'b1 || rdata !== 32'hFFFF_FFFF) begin
         nFails++; $display("FAIL reset_compare: sel=%b rdata=%h expected 1/ffffffff", sel, rdata);
      end
      nChecks++;
      if (irq !== 1'b0) begin
         nFails++; $display("FAIL reset_irq: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_compare_irq();
      int n;
      applyReset();
      busCycle(BASE + 32'h8, 1'b1, 32'd5);
      busCycle(BASE + 32'h0, 1'b1, 32'h5);
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
         busCycle(IDLE, 1'b0, 32'h0);
         n++;
      end
      nChecks++;
      if (n != 7) begin
         nFails++; $display("FAIL irq_latency: cycles=%0d expected 7", n);
      end
      busCycle(BASE + 32'h4, 1'b0, 32'h0);
      nChecks++;
      if (sel !== 1'b1 || rdata !== 32'd7) begin
         nFails++; $display("FAIL count_after_match: rdata=%h expected 00000007", rdata);
      end
      busCycle(BASE + 32'hC, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h1) begin
         nFails++; $display("FAIL status_match: rdata=%h expected 00000001", rdata);
      end
      busCycle(BASE + 32'hC, 1'b1, 32'h1);
      busCycle(IDLE, 1'b0, 32'h0);
      nChecks++;
      if (irq !== 1'b0) begin
         nFails++; $display("FAIL irq_clear: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] expSeq [6];
      expSeq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
      applyReset();
      busCycle(BASE + 32'h8, 1'b1, 32'd3);
      busCycle(BASE + 32'h0, 1'b1, 32'h3);
      for (int k = 0; k < 6; k++) begin
         busCycle(BASE + 32'h4, 1'b0, 32'h0);
         nChecks++;
         if (sel !== 1'b1 || rdata !== expSeq[k]) begin
            nFails++; $display("FAIL reload_seq[%0d]: rdata=%h expected %h", k, rdata, expSeq[k]);
         end
      end
      busCycle(BASE + 32'hC, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h1) begin
         nFails++; $display("FAIL reload_match: rdata=%h expected 00000001", rdata);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] expSeq [3];
      expSeq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      applyReset();
      busCycle(BASE + 32'h4, 1'b1, 32'hFFFF_FFFE);
      busCycle(BASE + 32'h8, 1'b1, 32'h10);
      busCycle(BASE + 32'h0, 1'b1, 32'h1);
      for (int k = 0; k < 3; k++) begin
         busCycle(BASE + 32'h4, 1'b0, 32'h0);
         nChecks++;
         if (rdata !== expSeq[k]) begin
            nFails++; $display("FAIL wrap_seq[%0d]: rdata=%h expected %h", k, rdata, expSeq[k]);
         end
      end
      busCycle(BASE + 32'hC, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h0) begin
         nFails++; $display("FAIL wrap_nomatch: rdata=%h expected 00000000", rdata);
      end
   endtask

   task automatic test_collisions();
      applyReset();
      busCycle(BASE + 32'h0, 1'b1, 32'h1);
      repeat (3) busCycle(IDLE, 1'b0, 32'h0);
      busCycle(BASE + 32'h4, 1'b1, 32'h100);
      busCycle(BASE + 32'h4, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h100) begin
         nFails++; $display("FAIL count_write_wins: rdata=%h expected 00000100", rdata);
      end
      applyReset();
      busCycle(BASE + 32'h8, 1'b1, 32'd2);
      busCycle(BASE + 32'h0, 1'b1, 32'h1);
      repeat (2) busCycle(IDLE, 1'b0, 32'h0);
      busCycle(BASE + 32'hC, 1'b1, 32'h1);
      busCycle(BASE + 32'hC, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h1) begin
         nFails++; $display("FAIL set_beats_w1c: rdata=%h expected 00000001", rdata);
      end
      busCycle(BASE + 32'hC, 1'b1, 32'hFFFF_FFFE);
      busCycle(BASE + 32'hC, 1'b0, 32'h0);
      nChecks++;
      if (rdata !== 32'h1) begin
         nFails++; $display("FAIL w1c_bit0_zero: rdata=%h expected 00000001", rdata);
      end
      busCycle(32'h0000_FE00, 1'b0, 32'h0);
      nChecks++;
      if (sel !== 1'b0 || rdata !== 32'h0) begin
         nFails++; $display("FAIL miss_read: sel=%b rdata=%h expected 0/00000000", sel, rdata);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] exp;
      applyReset();
      busCycle(BASE + 32'h0, 1'b1, 32'h0301);
      for (int k = 0; k < 9; k++) begin
         busCycle(BASE + 32'h4, 1'b0, 32'h0);
`ifdef MMIO_TIMER_PRESCALE_EN
         exp = 32'(k / 4);
`else
         exp = 32'(k);
`endif
         nChecks++;
         if (rdata !== exp) begin
            nFails++; $display("FAIL presc_count[%0d]: rdata=%h expected %h", k, rdata, exp);
         end
      end
      busCycle(BASE + 32'h0, 1'b0, 32'h0);
`ifdef MMIO_TIMER_PRESCALE_EN
      exp = 32'h0000_0301;
`else
      exp = 32'h0000_0001;
`endif
      nChecks++;
      if (rdata !== exp) begin
         nFails++; $display("FAIL presc_ctrl_read: rdata=%h expected %h", rdata, exp);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic        w;
      int          sel4;
      applyReset();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         sel4  = int'($urandom_range(0, 3));
         a     = BASE + 32'(sel4 * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = $urandom;
         w = ($urandom_range(0, 2) == 0);
         case (sel4)
            0:       d = $urandom & 32'h0000_0307;
            1, 2:    d = 32'($urandom_range(0, 24));
            default: d = $urandom;
         endcase
         busCycle(a, w, d);
         nChecks++;
         if (sel !== mSel || rdata !== mRdata || irq !== mIrq) begin
            nFails++;
            $display("FAIL random[%0d]: sel=%b rdata=%h irq=%b expected %b %h %b", i, sel, rdata, irq, mSel, mRdata, mIrq);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; addr = IDLE; wr = 1'b0; wdata = 32'h0;
      @(negedge clock);
      test_reset();
      test_compare_irq();
      test_auto_reload();
      test_wrap();
      test_collisions();
      test_prescale();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
